// File: rtl/data_mem_mmio.sv
// Data-memory stage: word-addressed RAM plus an MMIO page (LED, cycle counter, sticky fault).
// Optional timer compare/interrupt registers are built when MMIO_TIMER_EN is defined.
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
    parameter int          LED_W       = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic [LED_W-1:0] LED,
    output logic             addr_fault,
    output logic             timer_irq
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES  = 32'(DEPTH_WORDS * 4);
    localparam logic [5:0]  OFF_LED    = 6'h00;
    localparam logic [5:0]  OFF_CYCLE  = 6'h01;
    localparam logic [5:0]  OFF_STATUS = 6'h02;
    localparam logic [5:0]  OFF_TCMP   = 6'h03;
    localparam logic [5:0]  OFF_TCTRL  = 6'h04;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cycle_q, cycle_d;
    logic             fault_q, fault_d;

    logic             is_mmio, is_ram, aligned, bad_store, ram_we, mmio_we;
    logic [AW-1:0]    ram_idx;
    logic [5:0]       mmio_off;

    assign is_mmio   = (Addr[31:8] == MMIO_BASE[31:8]);
    assign is_ram    = !is_mmio && (Addr < RAM_BYTES);
    assign aligned   = (Addr[1:0] == 2'b00);
    assign bad_store = MemWrite && (!aligned || (!is_mmio && !is_ram));
    assign ram_we    = MemWrite && is_ram && aligned && !reset;
    assign mmio_we   = MemWrite && is_mmio && aligned;
    assign ram_idx   = Addr[AW+1:2];
    assign mmio_off  = Addr[7:2];

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        fault_d = fault_q;
        if (mmio_we && mmio_off == OFF_LED) begin
            led_d = WriteData[LED_W-1:0];
        end
        if (mmio_we && mmio_off == OFF_STATUS && WriteData[0]) begin
            fault_d = 1'b0;
        end
        // A bad store outranks a same-cycle clear.
        if (bad_store) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            led_q   <= '0;
            cycle_q <= '0;
            fault_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            fault_q <= fault_d;
        end
    end

    // RAM is never cleared; old data survives reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem_q[ram_idx] <= WriteData;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] tcmp_q, tcmp_d;
    logic        ten_q, ten_d;
    logic        tpend_q, tpend_d;

    always_comb begin
        tcmp_d  = tcmp_q;
        ten_d   = ten_q;
        tpend_d = tpend_q;
        if (mmio_we && mmio_off == OFF_TCMP) begin
            tcmp_d = WriteData;
        end
        if (mmio_we && mmio_off == OFF_TCTRL) begin
            ten_d = WriteData[0];
            if (WriteData[1]) begin
                tpend_d = 1'b0;
            end
        end
        if (ten_q && cycle_q == tcmp_q) begin
            tpend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            tcmp_q  <= '0;
            ten_q   <= 1'b0;
            tpend_q <= 1'b0;
        end else begin
            tcmp_q  <= tcmp_d;
            ten_q   <= ten_d;
            tpend_q <= tpend_d;
        end
    end

    assign timer_irq = tpend_q & ten_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        ReadData = '0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_LED:    ReadData = 32'(led_q);
                OFF_CYCLE:  ReadData = cycle_q;
                OFF_STATUS: ReadData = {31'd0, fault_q};
`ifdef MMIO_TIMER_EN
                OFF_TCMP:   ReadData = tcmp_q;
                OFF_TCTRL:  ReadData = {30'd0, tpend_q, ten_q};
`endif
                default:    ReadData = '0;
            endcase
        end else if (is_ram) begin
            ReadData = mem_q[ram_idx];
        end
    end

    assign LED        = led_q;
    assign addr_fault = fault_q;

endmodule
